seq_alu: RTL and testbench

//  Parametrised multi-cycle ALU for the multi-cycle CPU datapath, the successor to the combinational ALU.

---
 rtl/seq_alu.sv | 220 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the multi-cycle CPU datapath.
//   Single-cycle ops (add/sub/logic/shift/rotate) complete one cycle after
//   acceptance. Iterative MUL (shift-add) and DIVU/REMU (restoring divide)
//   take W steps. Result and NZCV flags are registered and held until the
//   next done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request, sampled only while busy=0
//   control    4-bit opcode, latched with start
//   A, B       W-bit operands, latched with start
//   out        registered result
//   N,Z,C,V    registered flags, updated only together with done
//   busy       iterative op in progress (start ignored)
//   done       one-cycle pulse: out/flags valid this cycle
//   fsm_state  debug view of the controller state (IDLE=0, ITER=1, FIN=2)
//
// Handshake: a request is accepted in any cycle where start=1 and busy=0,
// including the done cycle of the previous op. The op's result is presented
// with a one-cycle done pulse; there is no backpressure on the result side.
module seq_alu #(
  parameter int W      = 32,
  parameter int MUL_EN = 1,
  parameter int DIV_EN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   control,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] out,
  output logic         N,
  output logic         Z,
  output logic         C,
  output logic         V,
  output logic         busy,
  output logic         done,
  output logic [1:0]   fsm_state
);

  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST = SW'(W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIN = 2'd2} state_t;

  state_t state_q, state_d;

  logic [3:0]    op_q;
  logic [W-1:0]  m_q;      // multiplicand (MUL) or divisor (DIV)
  logic [2*W-1:0] p_q;     // MUL: {partial hi, multiplier lo}; DIV: {remainder, quotient}
  logic [SW-1:0] cnt_q;

  logic accept, is_mul, is_div, iter_op, last_step;

  assign is_mul    = (MUL_EN != 0) && (control == 4'd12);
  assign is_div    = (DIV_EN != 0) && ((control == 4'd13) || (control == 4'd14));
  assign iter_op   = is_mul || is_div;
  assign busy      = (state_q == ITER);
  assign accept    = start && !busy;
  assign last_step = (state_q == ITER) && (cnt_q == LAST);
  assign fsm_state = state_q;

  // ---------------- controller FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN: state_d = (accept && iter_op) ? ITER : IDLE;
      ITER:      if (last_step) state_d = FIN;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  logic [W-1:0]   add_x, add_y;
  logic           add_cin;
  logic [W:0]     add_sum;
  logic [SW-1:0]  amt;
  logic [SW:0]    ramt;
  logic [W:0]     lsl_w, lsr_w;
  logic signed [W:0] asr_in, asr_w;
  logic [W-1:0]   ror_r;
  logic [W-1:0]   sc_res;
  logic           sc_c, sc_v;

  assign amt  = B[SW-1:0];
  assign ramt = (SW+1)'(W) - {1'b0, amt};

  always_comb begin
    add_x   = A;
    add_y   = B;
    add_cin = 1'b0;
    if (control == 4'd1) begin
      add_y   = ~B;
      add_cin = 1'b1;
    end else if (control == 4'd2) begin
      add_x   = B;
      add_y   = ~A;
      add_cin = 1'b1;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    // Extra bit beside the operand catches the last bit shifted out;
    // it stays 0 when the amount is 0.
    lsl_w  = {1'b0, A} << amt;
    lsr_w  = {A, 1'b0} >> amt;
    asr_in = {A, 1'b0};
    asr_w  = asr_in >>> amt;
    ror_r  = (A >> amt) | (A << ramt);
  end

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (control)
      4'd0, 4'd1, 4'd2: begin
        sc_res = add_sum[W-1:0];
        sc_c   = add_sum[W];
        sc_v   = (add_x[W-1] == add_y[W-1]) && (add_sum[W-1] != add_x[W-1]);
      end
      4'd3:  sc_res = ~(A ^ B);
      4'd4:  sc_res = A & B;
      4'd5:  sc_res = A | B;
      4'd6:  sc_res = A ^ B;
      4'd8:  begin sc_res = lsl_w[W-1:0]; sc_c = lsl_w[W]; end
      4'd9:  begin sc_res = lsr_w[W:1];   sc_c = lsr_w[0]; end
      4'd10: begin sc_res = asr_w[W:1];   sc_c = asr_w[0]; end
      // The last bit rotated out lands in the MSB of the result.
      4'd11: begin sc_res = ror_r; sc_c = (amt != '0) && ror_r[W-1]; end
      default: sc_res = '0;  // 7, 15 and disabled 12-14
    endcase
  end

  // ---------------- iterative step ----------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_sh;
  logic           div_ge;
  logic [W-1:0]   div_r;
  logic [2*W-1:0] div_next, iter_next;
  logic [W-1:0]   it_res;
  logic           it_c, it_v;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, p_q[W-1:1]};
    // Restoring divide; with a zero divisor every trial subtract succeeds,
    // which yields an all-ones quotient and remainder = dividend.
    div_sh   = {p_q[2*W-1:W], p_q[W-1]};
    div_ge   = (div_sh >= {1'b0, m_q});
    div_r    = div_ge ? W'(div_sh - {1'b0, m_q}) : div_sh[W-1:0];
    div_next = {div_r, p_q[W-2:0], div_ge};
    iter_next = (op_q == 4'd12) ? mul_next : div_next;
    it_res = '0;
    it_c   = 1'b0;
    it_v   = 1'b0;
    case (op_q)
      4'd12: begin it_res = mul_next[W-1:0]; it_c = |mul_next[2*W-1:W]; end
      4'd13: begin it_res = div_next[W-1:0];   it_v = (m_q == '0); end
      4'd14: begin it_res = div_next[2*W-1:W]; it_v = (m_q == '0); end
      default: it_res = '0;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q  <= '0;
      m_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      out   <= '0;
      N     <= 1'b0;
      Z     <= 1'b0;
      C     <= 1'b0;
      V     <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q  <= control;
        cnt_q <= '0;
        if (is_mul) begin
          m_q <= A;
          p_q <= {{W{1'b0}}, B};
        end else begin
          m_q <= B;
          p_q <= {{W{1'b0}}, A};
        end
        if (!iter_op) begin
          out  <= sc_res;
          N    <= sc_res[W-1];
          Z    <= (sc_res == '0);
          C    <= sc_c;
          V    <= sc_v;
          done <= 1'b1;
        end
      end else if (state_q == ITER) begin
        p_q   <= iter_next;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) begin
          cnt_q <= '0;
          out   <= it_res;
          N     <= it_res[W-1];
          Z     <= (it_res == '0);
          C     <= it_c;
          V     <= it_v;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed + random bench for seq_alu at W=8.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   control = '0;
  logic [W-1:0] opa = '0, opb = '0;
  logic [W-1:0] out;
  logic         n_f, z_f, c_f, v_f, busy, done;
  logic [1:0]   fsm_state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // expected {out, N, Z, C, V} and the cycle it must appear in
  logic [W+3:0] exp_q[$];
  int           exp_cyc_q[$];

  seq_alu #(.W(W), .MUL_EN(1), .DIV_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .control(control),
    .A(opa), .B(opb), .out(out), .N(n_f), .Z(z_f), .C(c_f), .V(v_f),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c, v;
    logic [15:0]  p;
    int           amt, t;
    amt = int'(b[2:0]);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin t = int'(a) + int'(b); r = t[7:0]; c = (t > 255);
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin t = int'(a) - int'(b); r = t[7:0]; c = (a >= b);
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: begin t = int'(b) - int'(a); r = t[7:0]; c = (b >= a);
                  v = (a[7] != b[7]) && (r[7] != b[7]); end
      4'd3: r = ~(a ^ b);
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd8: begin r = a << amt; c = (amt != 0) ? a[8 - amt] : 1'b0; end
      4'd9: begin r = a >> amt; c = (amt != 0) ? a[amt - 1] : 1'b0; end
      4'd10: begin r = $signed(a) >>> amt; c = (amt != 0) ? a[amt - 1] : 1'b0; end
      4'd11: begin r = (a >> amt) | (a << (8 - amt)); c = (amt != 0) ? a[amt - 1] : 1'b0; end
      4'd12: begin p = a * b; r = p[7:0]; c = (p[15:8] != 0); end
      4'd13: begin if (b == 0) begin r = 8'hFF; v = 1'b1; end else r = a / b; end
      4'd14: begin if (b == 0) begin r = a; v = 1'b1; end else r = a % b; end
      default: r = '0;
    endcase
    return {r, r[7], (r == 0), c, v};
  endfunction

  function automatic bit is_iter(input logic [3:0] op);
    return (op == 4'd12) || (op == 4'd13) || (op == 4'd14);
  endfunction

  // ---------------- scoreboard: pop on done ----------------
  always @(negedge clk) begin
    if (reset_n && done) begin
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end
      if (exp_q.size() != 0) begin
        logic [W+3:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        assert ({out, n_f, z_f, c_f, v_f} === e) else begin
          mismatched++;
          $error("FAIL result: got out=%h NZCV=%b, required out=%h NZCV=%b",
                 out, {n_f, z_f, c_f, v_f}, e[W+3:4], e[3:0]);
        end
        compared++;
        assert (cyc === ec) else begin
          mismatched++;
          $error("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  // Holds start for one cycle, then scrambles the inputs.
  task automatic drive_start(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; control = op; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    control = 4'($urandom_range(0, 15));
    opa = 8'($urandom_range(0, 255));
    opb = 8'($urandom_range(0, 255));
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+3:0] exp);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + (is_iter(op) ? W + 1 : 1));
    drive_start(op, a, b);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL timeout: %0d results outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W+3:0] exp);
    issue(op, a, b, exp);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    // reset state
    #2;
    check("rst_out", 16'(out), 16'h00);
    check("rst_flags", 16'({n_f, z_f, c_f, v_f}), 16'h0);
    check("rst_busy_done", 16'({busy, done}), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // spec vectors
    run(4'd0,  8'h7F, 8'h01, {8'h80, 4'b1001});
    run(4'd1,  8'h05, 8'h07, {8'hFE, 4'b1000});
    run(4'd2,  8'h05, 8'h07, {8'h02, 4'b0010});
    run(4'd11, 8'h81, 8'h01, {8'hC0, 4'b1010});
    run(4'd8,  8'h81, 8'h00, {8'h81, 4'b1000});

    // MUL 0xFF*0xFF with busy profile
    issue(4'd12, 8'hFF, 8'hFF, {8'h01, 4'b0010});
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("mul_busy", 16'(busy), 16'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("mul_busy_end", 16'(busy), 16'h0);
    wait_drain();

    run(4'd13, 8'd200, 8'd7, {8'd28, 4'b0000});
    run(4'd14, 8'd200, 8'd7, {8'd4, 4'b0000});
    run(4'd13, 8'd9, 8'd0, {8'hFF, 4'b1001});
    run(4'd14, 8'd9, 8'd0, {8'h09, 4'b0001});

    // MUL 3*5 with start re-pulsed while busy
    issue(4'd12, 8'd3, 8'd5, {8'h0F, 4'b0000});
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; control = 4'd0; opa = 8'h10; opb = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;

    // back-to-back single-cycle ops
    issue(4'd4, 8'hF0, 8'h3C, model(4'd4, 8'hF0, 8'h3C));
    issue(4'd10, 8'h90, 8'h02, model(4'd10, 8'h90, 8'h02));
    issue(4'd7, 8'h12, 8'h34, {8'h00, 4'b0100});
    wait_drain();

    // start accepted in the done cycle of a DIVU
    issue(4'd13, 8'd100, 8'd9, model(4'd13, 8'd100, 8'd9));
    repeat (W) @(posedge clk);
    #1;
    issue(4'd0, 8'd1, 8'd2, {8'h03, 4'b0000});
    wait_drain();

    // random ops checked against the model
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom_range(0, 255));
      rb  = (i % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run(rop, ra, rb, model(rop, ra, rb));
    end

    // reset during a DIVU
    issue(4'd13, 8'd200, 8'd7, {8'd28, 4'b0000});
    repeat (3) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    check("midrst_out", 16'(out), 16'h00);
    check("midrst_flags", 16'({n_f, z_f, c_f, v_f}), 16'h0);
    check("midrst_busy_done", 16'({busy, done}), 16'h0);
    check("midrst_state", 16'(fsm_state), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    run(4'd0, 8'd1, 8'd1, {8'h02, 4'b0000});

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
